// File: rtl/sc_datapath_pkg.sv
// Shared encodings for the SC_STATEMACHINE datapath: ALU opcodes, bus mux sources,
// decoder idle code and shifter operation codes.
package sc_datapath_pkg;

  localparam logic [3:0] ALU_A   = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_NOT = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_INC = 4'b1010;
  localparam logic [3:0] ALU_DEC = 4'b1011;

  localparam logic [2:0] SEL_GEN0 = 3'b000;
  localparam logic [2:0] SEL_GEN1 = 3'b001;
  localparam logic [2:0] SEL_GEN2 = 3'b010;
  localparam logic [2:0] SEL_GEN3 = 3'b011;
  localparam logic [2:0] SEL_FIX0 = 3'b100;
  localparam logic [2:0] SEL_FIX1 = 3'b101;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam logic [2:0] DEC_NONE = 3'b111;

  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

endpackage

// File: rtl/sc_datapath_alu.sv
// Combinational ALU with active-high status flags; carry/overflow are meaningful
// only for the arithmetic opcodes and forced low otherwise.
module sc_datapath_alu
  import sc_datapath_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 8,
  parameter int DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic [DATAWIDTH_BUS-1:0]           alu_a,
  input  logic [DATAWIDTH_BUS-1:0]           alu_b,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] alu_op,
  output logic [DATAWIDTH_BUS-1:0]           alu_result,
  output logic                               overflow,
  output logic                               carry,
  output logic                               negative,
  output logic                               zero
);

  logic                      arith;
  logic                      cin;
  logic [DATAWIDTH_BUS-1:0]  b_eff;
  logic [DATAWIDTH_BUS:0]    uns_sum;
  logic signed [DATAWIDTH_BUS:0] sgn_sum;

  always_comb begin
    arith      = 1'b0;
    cin        = 1'b0;
    b_eff      = '0;
    alu_result = alu_a;
    case (alu_op)
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_NOT: alu_result = ~alu_a;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_ADD: begin arith = 1'b1; b_eff = alu_b; end
      ALU_SUB: begin arith = 1'b1; b_eff = ~alu_b; cin = 1'b1; end
      ALU_INC: begin arith = 1'b1; cin = 1'b1; end
      ALU_DEC: begin arith = 1'b1; b_eff = '1; end
      default: alu_result = alu_a;
    endcase

    // One adder serves all four arithmetic ops; the signed copy yields overflow.
    uns_sum = {1'b0, alu_a} + {1'b0, b_eff} + {{DATAWIDTH_BUS{1'b0}}, cin};
    sgn_sum = $signed({alu_a[DATAWIDTH_BUS-1], alu_a})
            + $signed({b_eff[DATAWIDTH_BUS-1], b_eff})
            + $signed({{DATAWIDTH_BUS{1'b0}}, cin});
    if (arith) alu_result = uns_sum[DATAWIDTH_BUS-1:0];

    carry    = arith & uns_sum[DATAWIDTH_BUS];
    overflow = arith & (sgn_sum[DATAWIDTH_BUS] ^ sgn_sum[DATAWIDTH_BUS-1]);
    negative = alu_result[DATAWIDTH_BUS-1];
    zero     = (alu_result == '0);
  end

endmodule

// File: rtl/sc_datapath_unit.sv
// Datapath for the SC_STATEMACHINE controller: register file, BUSA/BUSB muxes, ALU, shifter.
// Optional build macro SC_DATAPATH_ROTATE_EN: shifter code 00 rotates left instead of holding.
module sc_datapath_unit
  import sc_datapath_pkg::*;
#(
  parameter int                           DATAWIDTH_BUS                  = 8,
  parameter int                           DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int                           DATAWIDTH_MUX_SELECTION        = 3,
  parameter int                           DATAWIDTH_ALU_SELECTION        = 4,
  parameter int                           DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter logic [DATAWIDTH_BUS-1:0]     REGFIX0_VALUE                  = 8'hF6,
  parameter logic [DATAWIDTH_BUS-1:0]     REGFIX1_VALUE                  = 8'h01
) (
  input  logic                                      SC_STATEMACHINE_CLOCK_50,
  input  logic                                      SC_STATEMACHINE_RESET_InHigh,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderclearselection_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderloadselection_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSA_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSB_InBUS,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DATAPATH_aluselection_InBUS,
  input  logic                                      SC_DATAPATH_regSHIFTERclear_InLow,
  input  logic                                      SC_DATAPATH_regSHIFTERload_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DATAPATH_regSHIFTERshiftselection_InLow,
  output logic                                      SC_DATAPATH_overflow_OutLow,
  output logic                                      SC_DATAPATH_carry_OutLow,
  output logic                                      SC_DATAPATH_negative_OutLow,
  output logic                                      SC_DATAPATH_zero_OutLow,
  output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_BUSC_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_regGEN3_OutBUS
);

  logic [3:0][DATAWIDTH_BUS-1:0] gen_reg_p2;
  logic [DATAWIDTH_BUS-1:0]      shifter_p1;
  logic [DATAWIDTH_BUS-1:0]      bus_a;
  logic [DATAWIDTH_BUS-1:0]      bus_b;
  logic [DATAWIDTH_BUS-1:0]      alu_result;
  logic                          overflow, carry, negative, zero;

  function automatic logic [DATAWIDTH_BUS-1:0] bus_mux(
    input logic [DATAWIDTH_MUX_SELECTION-1:0] sel,
    input logic [3:0][DATAWIDTH_BUS-1:0]      regs
  );
    bus_mux = '0;
    case (sel)
      SEL_GEN0: bus_mux = regs[0];
      SEL_GEN1: bus_mux = regs[1];
      SEL_GEN2: bus_mux = regs[2];
      SEL_GEN3: bus_mux = regs[3];
      SEL_FIX0: bus_mux = REGFIX0_VALUE;
      SEL_FIX1: bus_mux = REGFIX1_VALUE;
      default:  bus_mux = '0;
    endcase
  endfunction

  always_comb begin
    bus_a = bus_mux(SC_DATAPATH_muxselectionBUSA_InBUS, gen_reg_p2);
    bus_b = bus_mux(SC_DATAPATH_muxselectionBUSB_InBUS, gen_reg_p2);
  end

  sc_datapath_alu #(
    .DATAWIDTH_BUS           (DATAWIDTH_BUS),
    .DATAWIDTH_ALU_SELECTION (DATAWIDTH_ALU_SELECTION)
  ) u_alu (
    .alu_a      (bus_a),
    .alu_b      (bus_b),
    .alu_op     (SC_DATAPATH_aluselection_InBUS),
    .alu_result (alu_result),
    .overflow   (overflow),
    .carry      (carry),
    .negative   (negative),
    .zero       (zero)
  );

  // Flags leave combinationally so the controller can branch in the issuing state.
  assign SC_DATAPATH_overflow_OutLow = ~overflow;
  assign SC_DATAPATH_carry_OutLow    = ~carry;
  assign SC_DATAPATH_negative_OutLow = ~negative;
  assign SC_DATAPATH_zero_OutLow     = ~zero;

  // Stage p1: ALU result -> shifter (BUSC)
  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
    if (SC_STATEMACHINE_RESET_InHigh) begin
      shifter_p1 <= '0;
    end else if (!SC_DATAPATH_regSHIFTERclear_InLow) begin
      shifter_p1 <= '0;
    end else if (!SC_DATAPATH_regSHIFTERload_InLow) begin
      shifter_p1 <= alu_result;
    end else begin
      case (SC_DATAPATH_regSHIFTERshiftselection_InLow)
        SH_LEFT:  shifter_p1 <= {shifter_p1[DATAWIDTH_BUS-2:0], 1'b0};
        SH_RIGHT: shifter_p1 <= {1'b0, shifter_p1[DATAWIDTH_BUS-1:1]};
`ifdef SC_DATAPATH_ROTATE_EN
        2'b00:    shifter_p1 <= {shifter_p1[DATAWIDTH_BUS-2:0], shifter_p1[DATAWIDTH_BUS-1]};
`endif
        default:  shifter_p1 <= shifter_p1;
      endcase
    end
  end

  // Stage p2: BUSC -> general registers; clear beats load on the same register
  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
    if (SC_STATEMACHINE_RESET_InHigh) begin
      gen_reg_p2 <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (SC_DATAPATH_decoderclearselection_InBUS == DATAWIDTH_DECODER_SELECTION'(n))
          gen_reg_p2[n] <= '0;
        else if (SC_DATAPATH_decoderloadselection_InBUS == DATAWIDTH_DECODER_SELECTION'(n))
          gen_reg_p2[n] <= shifter_p1;
      end
    end
  end

  assign SC_DATAPATH_BUSC_OutBUS    = shifter_p1;
  assign SC_DATAPATH_regGEN3_OutBUS = gen_reg_p2[3];

endmodule

// File: tb/tb_sc_datapath_unit.sv
// Self-checking bench for sc_datapath_unit: micro-op vector table with a scoreboard queue,
// plus hand-written reset and controller-style ABS sequences.
module tb_sc_datapath_unit;
  import sc_datapath_pkg::*;

  typedef struct packed {
    logic [2:0] clr, ld, ma, mb;
    logic [3:0] alu;
    logic       sclr_n, sld_n;
    logic [1:0] sh;
  } in_t;

  typedef struct {
    in_t        in;
    logic [3:0] fl;    // {overflow_n, carry_n, negative_n, zero_n}
    logic [7:0] busc;
    logic [7:0] gen3;
  } vec_t;

  localparam in_t IDLE = '{clr:3'b111, ld:3'b111, ma:3'b111, mb:3'b111,
                           alu:4'hF, sclr_n:1'b1, sld_n:1'b1, sh:2'b11};

  logic clk, rst;
  in_t  in0, in5;
  logic ovf0, car0, neg0, zer0, ovf5, car5, neg5, zer5;
  logic [7:0] busc0, gen30, busc5, gen35;

  int   n_total = 0;
  int   n_pass  = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  logic [7:0] rot_exp;

  sc_datapath_unit dut0 (
    .SC_STATEMACHINE_CLOCK_50                   (clk),
    .SC_STATEMACHINE_RESET_InHigh               (rst),
    .SC_DATAPATH_decoderclearselection_InBUS    (in0.clr),
    .SC_DATAPATH_decoderloadselection_InBUS     (in0.ld),
    .SC_DATAPATH_muxselectionBUSA_InBUS         (in0.ma),
    .SC_DATAPATH_muxselectionBUSB_InBUS         (in0.mb),
    .SC_DATAPATH_aluselection_InBUS             (in0.alu),
    .SC_DATAPATH_regSHIFTERclear_InLow          (in0.sclr_n),
    .SC_DATAPATH_regSHIFTERload_InLow           (in0.sld_n),
    .SC_DATAPATH_regSHIFTERshiftselection_InLow (in0.sh),
    .SC_DATAPATH_overflow_OutLow                (ovf0),
    .SC_DATAPATH_carry_OutLow                   (car0),
    .SC_DATAPATH_negative_OutLow                (neg0),
    .SC_DATAPATH_zero_OutLow                    (zer0),
    .SC_DATAPATH_BUSC_OutBUS                    (busc0),
    .SC_DATAPATH_regGEN3_OutBUS                 (gen30)
  );

  sc_datapath_unit #(.REGFIX0_VALUE(8'h05)) dut5 (
    .SC_STATEMACHINE_CLOCK_50                   (clk),
    .SC_STATEMACHINE_RESET_InHigh               (rst),
    .SC_DATAPATH_decoderclearselection_InBUS    (in5.clr),
    .SC_DATAPATH_decoderloadselection_InBUS     (in5.ld),
    .SC_DATAPATH_muxselectionBUSA_InBUS         (in5.ma),
    .SC_DATAPATH_muxselectionBUSB_InBUS         (in5.mb),
    .SC_DATAPATH_aluselection_InBUS             (in5.alu),
    .SC_DATAPATH_regSHIFTERclear_InLow          (in5.sclr_n),
    .SC_DATAPATH_regSHIFTERload_InLow           (in5.sld_n),
    .SC_DATAPATH_regSHIFTERshiftselection_InLow (in5.sh),
    .SC_DATAPATH_overflow_OutLow                (ovf5),
    .SC_DATAPATH_carry_OutLow                   (car5),
    .SC_DATAPATH_negative_OutLow                (neg5),
    .SC_DATAPATH_zero_OutLow                    (zer5),
    .SC_DATAPATH_BUSC_OutBUS                    (busc5),
    .SC_DATAPATH_regGEN3_OutBUS                 (gen35)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  function automatic vec_t V(input logic [2:0] clr, input logic [2:0] ld, input logic [2:0] ma,
                             input logic [2:0] mb, input logic [3:0] alu, input logic sclr_n,
                             input logic sld_n, input logic [1:0] sh, input logic [3:0] fl,
                             input logic [7:0] bc, input logic [7:0] g3);
    vec_t v;
    v.in   = '{clr:clr, ld:ld, ma:ma, mb:mb, alu:alu, sclr_n:sclr_n, sld_n:sld_n, sh:sh};
    v.fl   = fl;
    v.busc = bc;
    v.gen3 = g3;
    return v;
  endfunction

  task automatic drive(input bit which, input in_t s);
    if (which) in5 = s;
    else       in0 = s;
  endtask

  // Controller-style ABS: pass FIX0, branch on negative, negate via 0-x or copy, store in GenREG_3.
  task automatic abs_run(input bit which, input logic exp_neg_n, input logic [7:0] exp_g3);
    in_t  s;
    logic neg_n;
    s = IDLE; s.ma = SEL_FIX0; s.alu = ALU_A; s.sld_n = 1'b0;
    @(negedge clk); drive(which, s);
    #2 neg_n = which ? neg5 : neg0;
    chk("abs_negative_n", which, {7'b0, neg_n}, {7'b0, exp_neg_n});
    @(negedge clk);
    s = IDLE; s.sld_n = 1'b0;
    if (!neg_n) begin s.mb = SEL_FIX0; s.alu = ALU_SUB; end
    else        begin s.ma = SEL_FIX0; s.alu = ALU_A;   end
    drive(which, s);
    @(negedge clk);
    s = IDLE; s.ld = SEL_GEN3;
    drive(which, s);
    @(negedge clk); drive(which, IDLE);
    #1;
    chk("abs_gen3", which, which ? gen35 : gen30, exp_g3);
    chk("abs_busc", which, which ? busc5 : busc0, exp_g3);
  endtask

  initial begin
    vec_t v, e;
    logic [3:0] cap;
`ifdef SC_DATAPATH_ROTATE_EN
    rot_exp = 8'h03;
`else
    rot_exp = 8'h81;
`endif
    //          clr     ld      ma      mb      alu    sc    sl    sh     flags    busc   gen3
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b11, 4'b1110, 8'h00, 8'h00)); // 0 reset state
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hB, 1'b1, 1'b0, 2'b11, 4'b1101, 8'hFF, 8'h00)); // 1 0-1
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b10, 4'b1110, 8'h7F, 8'h00)); // 2 shr
    tbl.push_back(V(3'd7, 3'd0, 3'd5, 3'd7, 4'h0, 1'b1, 1'b0, 2'b11, 4'b1111, 8'h01, 8'h00)); // 3 G0=7F
    tbl.push_back(V(3'd7, 3'd1, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b11, 4'b1110, 8'h01, 8'h00)); // 4 G1=01
    tbl.push_back(V(3'd7, 3'd7, 3'd0, 3'd1, 4'h8, 1'b1, 1'b0, 2'b11, 4'b0101, 8'h80, 8'h00)); // 5 7F+01
    tbl.push_back(V(3'd7, 3'd2, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b11, 4'b1110, 8'h80, 8'h00)); // 6 G2=80
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hB, 1'b1, 1'b0, 2'b11, 4'b1101, 8'hFF, 8'h00)); // 7
    tbl.push_back(V(3'd7, 3'd0, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b11, 4'b1110, 8'hFF, 8'h00)); // 8 G0=FF
    tbl.push_back(V(3'd7, 3'd7, 3'd0, 3'd1, 4'h8, 1'b1, 1'b1, 2'b11, 4'b1010, 8'hFF, 8'h00)); // 9 FF+01
    tbl.push_back(V(3'd7, 3'd7, 3'd0, 3'd4, 4'h2, 1'b1, 1'b1, 2'b11, 4'b1101, 8'hFF, 8'h00)); // 10 AND
    tbl.push_back(V(3'd7, 3'd7, 3'd1, 3'd4, 4'h1, 1'b1, 1'b1, 2'b11, 4'b1101, 8'hFF, 8'h00)); // 11 OR
    tbl.push_back(V(3'd7, 3'd7, 3'd0, 3'd4, 4'h4, 1'b1, 1'b1, 2'b11, 4'b1111, 8'hFF, 8'h00)); // 12 XOR
    tbl.push_back(V(3'd7, 3'd7, 3'd1, 3'd7, 4'h3, 1'b1, 1'b1, 2'b11, 4'b1101, 8'hFF, 8'h00)); // 13 NOT
    tbl.push_back(V(3'd7, 3'd7, 3'd0, 3'd1, 4'h9, 1'b1, 1'b1, 2'b11, 4'b1001, 8'hFF, 8'h00)); // 14 FF-01
    tbl.push_back(V(3'd7, 3'd7, 3'd0, 3'd7, 4'hA, 1'b1, 1'b1, 2'b11, 4'b1010, 8'hFF, 8'h00)); // 15 INC FF
    tbl.push_back(V(3'd7, 3'd7, 3'd5, 3'd5, 4'h9, 1'b1, 1'b1, 2'b11, 4'b1010, 8'hFF, 8'h00)); // 16 1-1
    tbl.push_back(V(3'd7, 3'd7, 3'd2, 3'd1, 4'h1, 1'b1, 1'b0, 2'b11, 4'b1101, 8'h81, 8'h00)); // 17 Q=81
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b01, 4'b1110, 8'h02, 8'h00)); // 18 shl
    tbl.push_back(V(3'd7, 3'd7, 3'd2, 3'd1, 4'h1, 1'b1, 1'b0, 2'b11, 4'b1101, 8'h81, 8'h00)); // 19
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b10, 4'b1110, 8'h40, 8'h00)); // 20 shr
    tbl.push_back(V(3'd7, 3'd7, 3'd2, 3'd1, 4'h1, 1'b1, 1'b0, 2'b11, 4'b1101, 8'h81, 8'h00)); // 21
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b00, 4'b1110, rot_exp, 8'h00)); // 22
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b11, 4'b1110, rot_exp, 8'h00)); // 23 hold
    tbl.push_back(V(3'd7, 3'd7, 3'd2, 3'd1, 4'h1, 1'b0, 1'b0, 2'b01, 4'b1101, 8'h00, 8'h00)); // 24 clr wins
    tbl.push_back(V(3'd7, 3'd7, 3'd2, 3'd7, 4'h0, 1'b1, 1'b0, 2'b01, 4'b1101, 8'h80, 8'h00)); // 25 load wins
    tbl.push_back(V(3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b10, 4'b1110, 8'h40, 8'h00)); // 26
    tbl.push_back(V(3'd2, 3'd2, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b11, 4'b1110, 8'h40, 8'h00)); // 27 clr=ld
    tbl.push_back(V(3'd1, 3'd3, 3'd7, 3'd7, 4'hF, 1'b1, 1'b1, 2'b11, 4'b1110, 8'h40, 8'h40)); // 28
    tbl.push_back(V(3'd7, 3'd7, 3'd2, 3'd7, 4'h0, 1'b1, 1'b0, 2'b11, 4'b1110, 8'h00, 8'h40)); // 29 G2==0
    tbl.push_back(V(3'd7, 3'd7, 3'd1, 3'd7, 4'h0, 1'b1, 1'b1, 2'b11, 4'b1110, 8'h00, 8'h40)); // 30 G1==0
    tbl.push_back(V(3'd7, 3'd7, 3'd0, 3'd7, 4'h0, 1'b1, 1'b1, 2'b11, 4'b1101, 8'h00, 8'h40)); // 31 G0 kept
    tbl.push_back(V(3'd7, 3'd7, 3'd6, 3'd6, 4'h8, 1'b1, 1'b1, 2'b11, 4'b1110, 8'h00, 8'h40)); // 32 mux 110
    tbl.push_back(V(3'd7, 3'd7, 3'd4, 3'd7, 4'h5, 1'b1, 1'b1, 2'b11, 4'b1101, 8'h00, 8'h40)); // 33 op 0101
    tbl.push_back(V(3'd7, 3'd7, 3'd4, 3'd0, 4'hC, 1'b1, 1'b1, 2'b11, 4'b1101, 8'h00, 8'h40)); // 34 op 1100
    tbl.push_back(V(3'd7, 3'd7, 3'd5, 3'd7, 4'hB, 1'b1, 1'b1, 2'b11, 4'b1010, 8'h00, 8'h40)); // 35 DEC 01

    rst = 1'b1;
    in0 = IDLE;
    in5 = IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("reset_gen3_fix05", 0, gen35, 8'h00);
    chk("reset_busc_fix05", 0, busc5, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      in0 = v.in;
      exp_q.push_back(v);
      #2 cap = {ovf0, car0, neg0, zer0};
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("flags_n", i, {4'b0, cap}, {4'b0, e.fl});
      chk("busc", i, busc0, e.busc);
      chk("gen3", i, gen30, e.gen3);
    end

    // Reset between the shifter load and the GenREG load must abort the write.
    @(negedge clk);
    in0 = IDLE; in0.ma = SEL_FIX0; in0.alu = ALU_A; in0.sld_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_busc", 0, busc0, 8'hF6);
    @(negedge clk);
    in0 = IDLE; in0.ld = SEL_GEN3;
    #5 rst = 1'b1;
    #1;
    chk("rst_async_busc", 0, busc0, 8'h00);
    chk("rst_async_gen3", 0, gen30, 8'h00);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_post_gen3", 0, gen30, 8'h00);
    chk("rst_post_busc", 0, busc0, 8'h00);
    @(negedge clk);
    in0 = IDLE; in0.ma = SEL_GEN0; in0.alu = ALU_A;
    #2 chk("rst_post_gen0_flags_n", 0, {4'b0, ovf0, car0, neg0, zer0}, 8'h0E);
    @(negedge clk) in0 = IDLE;

    abs_run(1'b0, 1'b0, 8'h0A);
    abs_run(1'b1, 1'b1, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
